// File: rtl/fire_pkg.sv
// Shared state encoding and default timing constants for the trigger front-end,
// so the status/display logic can decode the state output.
package fire_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        FIRE         = 3'd1,
        COOLDOWN     = 3'd2,
        WAIT_RELEASE = 3'd3,
        FAULT        = 3'd4
    } fire_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_COOLDOWN_CYCLES = 25_000_000;
    localparam int DEF_STUCK_CYCLES    = 300_000_000;

endpackage

// File: rtl/fire_ctrl_debounce.sv
// Two-flop synchronizer followed by a counting debouncer; the output level only
// flips after the synced input has disagreed with it for DEBOUNCE_CYCLES cycles.
module debounce
    import fire_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic [CW-1:0] cnt_q;

    // Any sample that agrees with the current level restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            if (sync2_q != db_q) begin
                if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    db_q  <= ~db_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign dout = db_q;

endmodule

// File: rtl/fire_ctrl.sv
// Trigger front-end: debounced press detection, single shot per press, cooldown,
// stuck-trigger and external jam fault latching with a sticky error flag.
module fire_ctrl
    import fire_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
    parameter int STUCK_CYCLES    = DEF_STUCK_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       trigger,
    input  logic       fault_in,
    input  logic       clear_err,
    output logic       fire,
    output logic       error,
    output logic [2:0] state
);

    localparam int CCW = $clog2(COOLDOWN_CYCLES) + 1;
    localparam int SCW = $clog2(STUCK_CYCLES) + 1;

    fire_state_e    state_q;
    logic           fire_q;
    logic           error_q;
    logic           trigDb;
    logic           trigDb_q;
    logic           press;
    logic [CCW-1:0] coolCnt_q;
    logic [SCW-1:0] stuckCnt_q;

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .din  (trigger),
        .dout (trigDb)
    );

    assign press = trigDb & ~trigDb_q;

    // Cooldown loads COOLDOWN_CYCLES-1 so that FIRE + COOLDOWN + one IDLE cycle
    // gives a minimum shot spacing of COOLDOWN_CYCLES+2.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fire_q     <= 1'b0;
            error_q    <= 1'b0;
            trigDb_q   <= 1'b0;
            coolCnt_q  <= '0;
            stuckCnt_q <= '0;
        end else begin
            trigDb_q <= trigDb;
            fire_q   <= 1'b0;
            if (fault_in && (state_q != FAULT)) begin
                state_q <= FAULT;
                error_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (press && enable && !error_q) begin
                            state_q <= FIRE;
                            fire_q  <= 1'b1;
                        end
                    end
                    FIRE: begin
                        coolCnt_q <= CCW'(COOLDOWN_CYCLES - 1);
                        state_q   <= COOLDOWN;
                    end
                    COOLDOWN: begin
                        if (coolCnt_q == '0) begin
                            stuckCnt_q <= '0;
                            state_q    <= trigDb ? WAIT_RELEASE : IDLE;
                        end else begin
                            coolCnt_q <= coolCnt_q - 1'b1;
                        end
                    end
                    WAIT_RELEASE: begin
                        if (!trigDb) begin
                            state_q <= IDLE;
                        end else if (stuckCnt_q == SCW'(STUCK_CYCLES - 1)) begin
                            state_q <= FAULT;
                            error_q <= 1'b1;
                        end else begin
                            stuckCnt_q <= stuckCnt_q + 1'b1;
                        end
                    end
                    FAULT: begin
                        if (clear_err && !fault_in && !trigDb) begin
                            state_q <= IDLE;
                            error_q <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign fire  = fire_q;
    assign error = error_q;
    assign state = state_q;

endmodule

// File: tb/tb_fire_ctrl.sv
// Directed bench for fire_ctrl: expected fire edges are queued at stimulus time
// and a negedge monitor matches every observed fire pulse against the queue.
module tb_fire_ctrl;
    import fire_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       trigger;
    logic       fault_in;
    logic       clear_err;
    logic       fire;
    logic       error;
    logic [2:0] state;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int expQ[$];
    int expCyc;

    fire_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .COOLDOWN_CYCLES(8),
        .STUCK_CYCLES   (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .trigger  (trigger),
        .fault_in (fault_in),
        .clear_err(clear_err),
        .fire     (fire),
        .error    (error),
        .state    (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic t, input logic e, input logic f, input logic c);
        trigger   = t;
        enable    = e;
        fault_in  = f;
        clear_err = c;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Fire is expected on the 7th edge after the first edge that samples trigger=1.
    task automatic expectFire(input int after);
        expQ.push_back(cyc + after);
    endtask

    always @(negedge clk) begin
        if (fire !== 1'b0) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_fire: fire=%b at cycle %0d, expected 0", fire, cyc);
            end else begin
                expCyc = expQ.pop_front();
                checkOutput("fire_cycle", cyc, expCyc);
            end
        end
    end

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(3);
        checkOutput("reset_state", state, IDLE);
        checkOutput("reset_fire", fire, 0);
        checkOutput("reset_error", error, 0);
        reset = 1'b0;
        tick(2);

        $display("[TB] test 1: clean press");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        expectFire(7);
        tick(7);
        checkOutput("t1_state_fire", state, FIRE);
        tick(1);
        checkOutput("t1_state_cooldown", state, COOLDOWN);
        tick(8);
        checkOutput("t1_state_wait", state, WAIT_RELEASE);
        tick(4);
        trigger = 1'b0;
        tick(7);
        checkOutput("t1_state_idle", state, IDLE);
        checkOutput("t1_error", error, 0);
        tick(5);

        $display("[TB] test 2: bounce");
        for (int i = 0; i < 3; i++) begin
            trigger = 1'b1;
            tick(2);
            trigger = 1'b0;
            tick(2);
        end
        checkOutput("t2_idle_after_bounce", state, IDLE);
        trigger = 1'b1;
        expectFire(7);
        tick(16);
        trigger = 1'b0;
        tick(8);
        checkOutput("t2_idle_end", state, IDLE);
        tick(5);

        $display("[TB] test 3: rapid presses");
        trigger = 1'b1;
        expectFire(7);
        tick(6);
        trigger = 1'b0;
        tick(2);
        trigger = 1'b1;
        tick(6);
        checkOutput("t3_in_cooldown", state, COOLDOWN);
        trigger = 1'b0;
        tick(10);
        trigger = 1'b1;
        expectFire(7);
        tick(6);
        trigger = 1'b0;
        tick(12);
        checkOutput("t3_idle_end", state, IDLE);
        tick(5);

        $display("[TB] test 4: stuck trigger");
        trigger = 1'b1;
        expectFire(7);
        tick(31);
        checkOutput("t4_still_wait", state, WAIT_RELEASE);
        tick(1);
        checkOutput("t4_fault", state, FAULT);
        checkOutput("t4_error_set", error, 1);
        clear_err = 1'b1;
        tick(2);
        checkOutput("t4_clear_while_held", state, FAULT);
        clear_err = 1'b0;
        tick(26);
        trigger = 1'b0;
        tick(10);
        checkOutput("t4_fault_before_clear", state, FAULT);
        clear_err = 1'b1;
        tick(1);
        checkOutput("t4_cleared_state", state, IDLE);
        checkOutput("t4_cleared_error", error, 0);
        clear_err = 1'b0;
        tick(5);

        $display("[TB] test 5: external fault");
        trigger = 1'b1;
        expectFire(7);
        tick(6);
        trigger = 1'b0;
        tick(4);
        checkOutput("t5_in_cooldown", state, COOLDOWN);
        fault_in  = 1'b1;
        clear_err = 1'b1;
        tick(1);
        checkOutput("t5_fault", state, FAULT);
        checkOutput("t5_error", error, 1);
        tick(3);
        checkOutput("t5_clear_with_fault", state, FAULT);
        fault_in  = 1'b0;
        clear_err = 1'b0;
        trigger   = 1'b1;
        tick(6);
        trigger = 1'b0;
        tick(4);
        checkOutput("t5_press_in_fault", state, FAULT);
        tick(6);
        clear_err = 1'b1;
        tick(1);
        checkOutput("t5_cleared_state", state, IDLE);
        checkOutput("t5_cleared_error", error, 0);
        clear_err = 1'b0;
        tick(5);

        $display("[TB] test 6: enable and reset");
        enable  = 1'b0;
        trigger = 1'b1;
        tick(6);
        trigger = 1'b0;
        tick(4);
        enable = 1'b1;
        tick(10);
        checkOutput("t6_disabled_idle", state, IDLE);
        trigger = 1'b1;
        expectFire(7);
        tick(6);
        trigger = 1'b0;
        tick(4);
        checkOutput("t6_in_cooldown", state, COOLDOWN);
        reset = 1'b1;
        tick(1);
        checkOutput("t6_reset_state", state, IDLE);
        checkOutput("t6_reset_fire", fire, 0);
        checkOutput("t6_reset_error", error, 0);
        reset = 1'b0;
        tick(3);
        trigger = 1'b1;
        expectFire(7);
        tick(6);
        trigger = 1'b0;
        tick(30);
        checkOutput("t6_idle_end", state, IDLE);

        checkOutput("pending_fires", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fire_ctrl.md
Name: fire_ctrl

Overview:
Front-end for the shot counter. It conditions the raw trigger pushbutton with a 2-FF synchronizer and a debouncer, then enforces single-shot-per-press and a cooldown. It produces the one-clock `fire` pulse and the sticky `error` level that the BCD shot counter consumes. It also latches jam faults from the external sensor and from a trigger held too long.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive cycles the synced input must differ from the debounced level before that level flips (10 ms at 100 MHz).
- COOLDOWN_CYCLES, 25_000_000, cycles spent in COOLDOWN after each shot (250 ms).
- STUCK_CYCLES, 300_000_000, cycles the trigger may stay held in WAIT_RELEASE before a fault (3 s).

Ports:
- clk, in, 1, system clock (100 MHz).
- reset, in, 1, synchronous, active-high reset.
- enable, in, 1, arms the block; a new shot is accepted only when high.
- trigger, in, 1, raw asynchronous pushbutton.
- fault_in, in, 1, external jam sensor, active-high level.
- clear_err, in, 1, clears a latched error (level, sampled each clk).
- fire, out, 1, registered one-clk pulse per accepted shot.
- error, out, 1, registered sticky fault flag.
- state, out, 3, current FSM state encoding, for status LEDs.

Behaviour:
- Reset and clocking:
  - One clock, clk. Reset is synchronous and active-high on `reset`. Every register updates only on posedge clk.
  - Reset values: fire=0, error=0, state=IDLE, sync FFs=0, debounced level trig_db=0, all counters=0.
  - Reset mid-operation aborts any cooldown or fault immediately.
- Synchronizer and debounce:
  - trigger passes through 2 FFs to give trig_s.
  - A debounce counter increments while trig_s != trig_db and clears to 0 when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, trig_db toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes trig_db.
- Rising-edge detect:
  - press = trig_db & ~trig_db_q, where trig_db_q is trig_db delayed one clk.
- FSM encoding: IDLE=0, FIRE=1, COOLDOWN=2, WAIT_RELEASE=3, FAULT=4.
- FSM transitions:
  - IDLE: if press & enable & ~error, go to FIRE. Otherwise stay. A press while enable=0 is discarded, not queued.
  - FIRE: lasts exactly one cycle; the fire register is high for that cycle only. Load the cooldown counter, then go to COOLDOWN.
  - COOLDOWN: decrement the counter. At 0, go to WAIT_RELEASE if trig_db=1, else to IDLE. enable falling here does not abort; presses here are ignored.
  - WAIT_RELEASE: count cycles with trig_db=1. On trig_db=0, go to IDLE. If the count reaches STUCK_CYCLES, go to FAULT and set error.
  - FAULT: fire is held 0. Exit to IDLE only when clear_err=1 & fault_in=0 & trig_db=0; error is cleared the same edge.
- fault_in: a high value in any state other than FAULT forces FAULT and sets error on the next edge. fault_in wins over clear_err and over a simultaneous press.
- error: sticky. It is cleared only by reset or by the FAULT exit above. clear_err outside FAULT has no effect.
- Latency: from the first clk edge that samples trigger=1 (held stable) to the edge that sets fire=1 is exactly DEBOUNCE_CYCLES+3 edges.
- Minimum spacing between consecutive fire pulses is COOLDOWN_CYCLES+2 cycles.
- Trigger held across reset release: trig_db rises after debounce, which produces exactly one shot. This is accepted behaviour.
- Counter widths: $clog2 of the respective parameter +1. No wrap is possible because every counter saturates or reloads.

Decomposition:
- Shared package/header `fire_pkg`: the state encoding localparams (IDLE..FAULT) and the default timing constants, so the display FSM can decode `state`.
- One sub-module, `debounce`, parameterised by DEBOUNCE_CYCLES. It contains the synchronizer, counter and trig_db register, and is reusable for the reset button.
- The FSM, cooldown counter and stuck counter stay in fire_ctrl.

Test Plan:
Bench uses DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8, STUCK_CYCLES=16.
1. Clean press: enable=1, trigger high for 20 cycles then low -> one fire pulse, 1 cycle wide, at edge 7 after the first sample; state goes 0 -> 1 -> 2 -> 3 -> 0; error stays 0.
2. Bounce: trigger toggles every 2 cycles for 12 cycles, then stays high -> no fire during the bounce; exactly one fire 7 edges after the final rise.
3. Rapid presses: two clean 6-cycle presses separated by 2 cycles low -> the second press, which lands in COOLDOWN, produces no fire; a third press after COOLDOWN fires.
4. Stuck trigger: trigger held for 60 cycles -> one fire, then FAULT after 16 cycles in WAIT_RELEASE, error=1. clear_err while still held -> stays FAULT. Release and wait for debounce, then clear_err=1 -> IDLE, error=0.
5. External fault: pulse fault_in in COOLDOWN -> FAULT next edge, error=1. clear_err asserted together with fault_in -> remains FAULT. A press while in FAULT -> no fire.
6. Enable and reset: a press with enable=0 -> no fire, and no fire when enable later rises. reset asserted during COOLDOWN -> next edge state=0, fire=0, error=0, counters 0.
